// File: rtl/regfile_dump.sv
// regfile_dump: RV32I integer register file (x0 hard-wired to zero) with two
// combinational read ports, one write port, and a debug dump engine that
// streams x0..x(NREG-1) out over a valid/ready handshake.
// Optional feature macro: WRITE_BYPASS_EN
//   defined   -> same-cycle write data is forwarded to the read ports and to a
//                dump beat loaded on the write edge of the same index.
//   undefined -> reads and dump loads see the pre-write register value.
module regfile_dump #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    output logic [XLEN-1:0] rs1_data,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] rd_data,
    input  logic            dump_start,
    output logic            dump_busy,
    output logic            dump_valid,
    input  logic            dump_ready,
    output logic [AW-1:0]   dump_idx,
    output logic [XLEN-1:0] dump_data,
    output logic            dump_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0]   IDX_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0]   IDX_ONE   = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]   IDX_LAST  = AW'(NREG - 1);
    localparam logic [XLEN-1:0] DATA_ZERO = {XLEN{1'b0}};

    logic [XLEN-1:0] regs_r [NREG];

    state_t          state_r;
    state_t          state_nxt_s;
    logic            valid_r;
    logic            busy_r;
    logic            done_r;
    logic [AW-1:0]   idx_r;
    logic [XLEN-1:0] data_r;

    logic            valid_nxt_s;
    logic            busy_nxt_s;
    logic            done_nxt_s;
    logic [AW-1:0]   idx_nxt_s;
    logic [XLEN-1:0] data_nxt_s;

    logic            wr_en_s;
    logic            accept_s;
    logic            last_s;
    logic [AW-1:0]   idx_inc_s;
    logic [XLEN-1:0] load_data_s;

    // x0 is never written, so a write to index 0 is simply dropped.
    assign wr_en_s   = we && (rd_addr != IDX_ZERO);
    assign accept_s  = valid_r && dump_ready;
    assign last_s    = (idx_r == IDX_LAST);
    assign idx_inc_s = idx_r + IDX_ONE;

`ifdef WRITE_BYPASS_EN
    // Forward write data to a read of the index being written this cycle.
    assign rs1_data = (rs1_addr == IDX_ZERO) ? DATA_ZERO :
                      (wr_en_s && (rd_addr == rs1_addr)) ? rd_data : regs_r[rs1_addr];
    assign rs2_data = (rs2_addr == IDX_ZERO) ? DATA_ZERO :
                      (wr_en_s && (rd_addr == rs2_addr)) ? rd_data : regs_r[rs2_addr];
    // A dump beat loaded on the write edge of its own index takes the new value.
    assign load_data_s = (wr_en_s && (rd_addr == idx_inc_s)) ? rd_data : regs_r[idx_inc_s];
`else
    // Reads return the stored value; a same-cycle write becomes visible next cycle.
    assign rs1_data = (rs1_addr == IDX_ZERO) ? DATA_ZERO : regs_r[rs1_addr];
    assign rs2_data = (rs2_addr == IDX_ZERO) ? DATA_ZERO : regs_r[rs2_addr];
    // Dump loads sample the pre-write register value.
    assign load_data_s = regs_r[idx_inc_s];
`endif

    // Register array storage: cleared on reset, written by the WB stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= DATA_ZERO;
            end
        end else if (wr_en_s) begin
            regs_r[rd_addr] <= rd_data;
        end
    end

    // Dump FSM state and registered dump outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            idx_r   <= IDX_ZERO;
            data_r  <= DATA_ZERO;
        end else begin
            state_r <= state_nxt_s;
            valid_r <= valid_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            idx_r   <= idx_nxt_s;
            data_r  <= data_nxt_s;
        end
    end

    // Next-state logic: start only from IDLE, leave SCAN after the last beat.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (dump_start) begin
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (accept_s && last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered beat, busy and done flags.
    always_comb begin
        valid_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
        done_nxt_s  = 1'b0;
        idx_nxt_s   = idx_r;
        data_nxt_s  = data_r;
        case (state_r)
            ST_IDLE: begin
                if (dump_start) begin
                    valid_nxt_s = 1'b1;
                    busy_nxt_s  = 1'b1;
                    idx_nxt_s   = IDX_ZERO;
                    data_nxt_s  = DATA_ZERO;
                end else begin
                    valid_nxt_s = 1'b0;
                    busy_nxt_s  = 1'b0;
                end
            end
            ST_SCAN: begin
                busy_nxt_s = 1'b1;
                if (accept_s) begin
                    if (last_s) begin
                        valid_nxt_s = 1'b0;
                        done_nxt_s  = 1'b1;
                    end else begin
                        valid_nxt_s = 1'b1;
                        idx_nxt_s   = idx_inc_s;
                        data_nxt_s  = load_data_s;
                    end
                end else begin
                    // Stall: beat held unchanged, later writes do not disturb it.
                    valid_nxt_s = 1'b1;
                end
            end
            ST_DONE: begin
                valid_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b0;
            end
            default: begin
                valid_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b0;
            end
        endcase
    end

    assign dump_valid = valid_r;
    assign dump_busy  = busy_r;
    assign dump_done  = done_r;
    assign dump_idx   = idx_r;
    assign dump_data  = data_r;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: reference register model plus a
// queue of expected dump beats filled when a dump is started.
module tb_regfile_dump;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   rs1_addr;
    logic [XLEN-1:0] rs1_data;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs2_data;
    logic            we;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            dump_start;
    logic            dump_busy;
    logic            dump_valid;
    logic            dump_ready;
    logic [AW-1:0]   dump_idx;
    logic [XLEN-1:0] dump_data;
    logic            dump_done;

    int total = 0;
    int bad   = 0;

    logic [XLEN-1:0] model [NREG];
    logic [AW-1:0]   exp_idx_q [$];
    logic [XLEN-1:0] exp_data_q [$];

    regfile_dump #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .rs1_addr   (rs1_addr),
        .rs1_data   (rs1_data),
        .rs2_addr   (rs2_addr),
        .rs2_data   (rs2_data),
        .we         (we),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .dump_start (dump_start),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    always #5 clk = ~clk;

    // Expected beats for a dump are the model contents at the moment it starts.
    task automatic push_dump_expect();
        for (int i = 0; i < NREG; i++) begin
            exp_idx_q.push_back(AW'(i));
            exp_data_q.push_back((i == 0) ? 32'h0 : model[i]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
        rd_addr = 5'd0; rd_data = 32'h0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        for (int i = 0; i < NREG; i++) model[i] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: got valid=%b busy=%b done=%b want 0/0/0", dump_valid, dump_busy, dump_done);
        end
        total++;
        if (dump_idx !== 5'd0 || dump_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_beat: got idx=%0d data=%h want 0/0", dump_idx, dump_data);
        end
        for (int i = 1; i < NREG; i++) begin
            rs1_addr = AW'(i);
            rs2_addr = AW'(NREG - i);
            #1;
            total++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
                bad++;
                $display("FAIL reset_read x%0d: got rs1=%h rs2=%h want 0", i, rs1_data, rs2_data);
            end
        end
    endtask

    task automatic test_x0_write();
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'hDEADBEEF; rs1_addr = 5'd0;
        @(negedge clk);
        we = 1'b0;
        #1;
        total++;
        if (rs1_data !== 32'h0) begin
            bad++;
            $display("FAIL x0_write: got %h want 00000000", rs1_data);
        end
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] same_exp;
`ifdef WRITE_BYPASS_EN
        same_exp = 32'h12345678;
`else
        same_exp = model[5];
`endif
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd5; rd_data = 32'h12345678; rs1_addr = 5'd5; rs2_addr = 5'd5;
        #1;
        total++;
        if (rs1_data !== same_exp || rs2_data !== same_exp) begin
            bad++;
            $display("FAIL bypass_same_cycle: got rs1=%h rs2=%h want %h", rs1_data, rs2_data, same_exp);
        end
        @(negedge clk);
        we = 1'b0;
        model[5] = 32'h12345678;
        #1;
        total++;
        if (rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678) begin
            bad++;
            $display("FAIL bypass_next_cycle: got rs1=%h rs2=%h want 12345678", rs1_data, rs2_data);
        end
    endtask

    task automatic test_full_dump();
        int beats = 0, dones = 0, busy_cyc = 0, last_k = -10, done_k = -20;
        logic [AW-1:0]   ei;
        logic [XLEN-1:0] ed;
        // Preload xi = i*3.
        for (int i = 1; i < NREG; i++) begin
            @(negedge clk);
            we = 1'b1; rd_addr = AW'(i); rd_data = XLEN'(i * 3);
            model[i] = XLEN'(i * 3);
        end
        @(negedge clk);
        we = 1'b0; dump_start = 1'b1; dump_ready = 1'b1;
        push_dump_expect();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            dump_start = 1'b0;
            #1;
            if (dump_busy) busy_cyc++;
            if (dump_done) begin dones++; done_k = k; end
            if (dump_valid && dump_ready) begin
                total++;
                if (exp_idx_q.size() == 0) begin
                    bad++;
                    $display("FAIL full_beat unexpected: got idx=%0d data=%h want no beat", dump_idx, dump_data);
                end else begin
                    ei = exp_idx_q.pop_front();
                    ed = exp_data_q.pop_front();
                    beats++;
                    last_k = k;
                    if (dump_idx !== ei || dump_data !== ed) begin
                        bad++;
                        $display("FAIL full_beat: got idx=%0d data=%h want idx=%0d data=%h", dump_idx, dump_data, ei, ed);
                    end
                end
            end
        end
        total++;
        if (beats != 32 || exp_idx_q.size() != 0) begin
            bad++;
            $display("FAIL full_beat_count: got %0d beats (%0d left) want 32", beats, exp_idx_q.size());
        end
        total++;
        if (dones != 1 || done_k != last_k + 1) begin
            bad++;
            $display("FAIL full_done: got %0d pulses at %0d want 1 at %0d", dones, done_k, last_k + 1);
        end
        total++;
        if (busy_cyc != 33) begin
            bad++;
            $display("FAIL full_busy_cycles: got %0d want 33", busy_cyc);
        end
    endtask

    task automatic test_stall();
        int stall_cnt = 0, dones = 0;
        logic [AW-1:0]   ei;
        logic [XLEN-1:0] ed;
        logic [XLEN-1:0] old7;
        old7 = model[7];
        @(negedge clk);
        dump_start = 1'b1; dump_ready = 1'b1;
        push_dump_expect();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            dump_start = 1'b0; we = 1'b0;
            if (dump_valid && dump_idx == 5'd7 && stall_cnt < 4) begin
                dump_ready = 1'b0;
                if (stall_cnt == 0) begin
                    we = 1'b1; rd_addr = 5'd7; rd_data = 32'hAAAA5555;
                end
                if (stall_cnt == 2) dump_start = 1'b1;
                stall_cnt++;
            end else begin
                dump_ready = 1'b1;
            end
            #1;
            if (!dump_ready) begin
                total++;
                if (dump_valid !== 1'b1 || dump_idx !== 5'd7 || dump_data !== old7) begin
                    bad++;
                    $display("FAIL stall_hold: got valid=%b idx=%0d data=%h want 1/7/%h", dump_valid, dump_idx, dump_data, old7);
                end
            end
            if (dump_done) dones++;
            if (dump_valid && dump_ready) begin
                total++;
                if (exp_idx_q.size() == 0) begin
                    bad++;
                    $display("FAIL stall_beat unexpected: got idx=%0d data=%h want no beat", dump_idx, dump_data);
                end else begin
                    ei = exp_idx_q.pop_front();
                    ed = exp_data_q.pop_front();
                    if (dump_idx !== ei || dump_data !== ed) begin
                        bad++;
                        $display("FAIL stall_beat: got idx=%0d data=%h want idx=%0d data=%h", dump_idx, dump_data, ei, ed);
                    end
                end
            end
        end
        model[7] = 32'hAAAA5555;
        total++;
        if (stall_cnt != 4 || exp_idx_q.size() != 0) begin
            bad++;
            $display("FAIL stall_progress: got stalls=%0d left=%0d want 4/0", stall_cnt, exp_idx_q.size());
        end
        total++;
        if (dones != 1 || dump_busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_start_ignored: got dones=%0d busy=%b want 1/0", dones, dump_busy);
        end
        rs1_addr = 5'd7;
        #1;
        total++;
        if (rs1_data !== 32'hAAAA5555) begin
            bad++;
            $display("FAIL stall_write: got %h want aaaa5555", rs1_data);
        end
    endtask

    task automatic test_reset_mid_dump();
        int found = 0, dones = 0;
        logic [AW-1:0]   ei;
        logic [XLEN-1:0] ed;
        @(negedge clk);
        dump_start = 1'b1; dump_ready = 1'b1;
        push_dump_expect();
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            dump_start = 1'b0;
            #1;
            if (dump_valid && dump_idx == 5'd12) begin
                found = 1;
                break;
            end
            if (dump_valid && dump_ready) begin
                ei = exp_idx_q.pop_front();
                ed = exp_data_q.pop_front();
                total++;
                if (dump_idx !== ei || dump_data !== ed) begin
                    bad++;
                    $display("FAIL rst_pre_beat: got idx=%0d data=%h want idx=%0d data=%h", dump_idx, dump_data, ei, ed);
                end
            end
        end
        total++;
        if (found == 0) begin
            bad++;
            $display("FAIL rst_reach_idx12: got timeout want idx 12");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_idx_q.delete();
        exp_data_q.delete();
        for (int i = 0; i < NREG; i++) model[i] = 32'h0;
        #1;
        total++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0 || dump_idx !== 5'd0 || dump_data !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got valid=%b busy=%b done=%b idx=%0d data=%h want all 0",
                     dump_valid, dump_busy, dump_done, dump_idx, dump_data);
        end
        for (int i = 1; i < NREG; i++) begin
            rs1_addr = AW'(i);
            rs2_addr = AW'(i);
            #1;
            total++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
                bad++;
                $display("FAIL rst_mid_regs x%0d: got rs1=%h rs2=%h want 0", i, rs1_data, rs2_data);
            end
        end
        @(negedge clk);
        dump_start = 1'b1;
        push_dump_expect();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            dump_start = 1'b0;
            #1;
            if (k == 0) begin
                total++;
                if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_idx !== 5'd0) begin
                    bad++;
                    $display("FAIL rst_restart: got valid=%b busy=%b idx=%0d want 1/1/0", dump_valid, dump_busy, dump_idx);
                end
            end
            if (dump_done) dones++;
            if (dump_valid && dump_ready) begin
                total++;
                if (exp_idx_q.size() == 0) begin
                    bad++;
                    $display("FAIL rst_beat unexpected: got idx=%0d want no beat", dump_idx);
                end else begin
                    ei = exp_idx_q.pop_front();
                    ed = exp_data_q.pop_front();
                    if (dump_idx !== ei || dump_data !== ed) begin
                        bad++;
                        $display("FAIL rst_beat: got idx=%0d data=%h want idx=%0d data=%h", dump_idx, dump_data, ei, ed);
                    end
                end
            end
        end
        total++;
        if (dones != 1 || exp_idx_q.size() != 0) begin
            bad++;
            $display("FAIL rst_redump_end: got dones=%0d left=%0d want 1/0", dones, exp_idx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_x0_write();
        test_bypass();
        test_full_dump();
        test_stall();
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
